// File: rtl/row_frame_buffer.sv
// Double-buffered row store: host fills the back bank, and a commit
// swaps banks only at the frame wrap so the display never tears.
module row_frame_buffer #(
    parameter int NUM_ROWS = 4,
    parameter int PTR_BITS = $clog2(NUM_ROWS),
    parameter int NUM_COLS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PTR_BITS-1:0] row_ptr,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [PTR_BITS-1:0] wr_row,
    input  logic [NUM_COLS-1:0] wr_data,
    input  logic                commit_valid,
    output logic                commit_ready,
    output logic                swap_done,
    output logic [NUM_ROWS-1:0] row_sel,
    output logic [NUM_COLS-1:0] col_data,
    output logic                frame_start
);

    typedef enum logic {
        OPEN    = 1'b0,
        PENDING = 1'b1
    } state_t;

    typedef logic [1:0][NUM_ROWS-1:0][NUM_COLS-1:0] banks_t;

    state_t                state_q, state_d;
    logic                  front_sel_q, front_sel_d;
    banks_t                bank_q, bank_d;
    logic                  swap_done_q, swap_done_d;
    logic [NUM_ROWS-1:0]   row_sel_q, row_sel_d;
    logic [NUM_COLS-1:0]   col_data_q, col_data_d;
    logic                  frame_start_q, frame_start_d;

    logic back_sel;
    logic last_row;

    assign back_sel = ~front_sel_q;
    assign last_row = (row_ptr == PTR_BITS'(NUM_ROWS - 1));

    assign wr_ready     = (state_q == OPEN);
    assign commit_ready = (state_q == OPEN);

    always_comb begin
        state_d     = state_q;
        front_sel_d = front_sel_q;
        bank_d      = bank_q;
        swap_done_d = 1'b0;
        unique case (state_q)
            OPEN: begin
                // A write landing with the commit is part of the swapped frame
                if (wr_valid) begin
                    bank_d[back_sel][wr_row] = wr_data;
                end
                if (commit_valid) begin
                    state_d = PENDING;
                end
            end
            PENDING: begin
                if (last_row) begin
                    front_sel_d = back_sel;
                    swap_done_d = 1'b1;
                    state_d     = OPEN;
                end
            end
            default: state_d = OPEN;
        endcase
    end

    // Read uses the pre-edge front bank, so the last row still shows the old frame
    always_comb begin
        row_sel_d     = NUM_ROWS'(1) << row_ptr;
        col_data_d    = bank_q[front_sel_q][row_ptr];
        frame_start_d = (row_ptr == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= OPEN;
            front_sel_q   <= 1'b0;
            bank_q        <= '0;
            swap_done_q   <= 1'b0;
            row_sel_q     <= '0;
            col_data_q    <= '0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            front_sel_q   <= front_sel_d;
            bank_q        <= bank_d;
            swap_done_q   <= swap_done_d;
            row_sel_q     <= row_sel_d;
            col_data_q    <= col_data_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign swap_done   = swap_done_q;
    assign row_sel     = row_sel_q;
    assign col_data    = col_data_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_row_frame_buffer.sv
// Bench for row_frame_buffer: vector table, corner-case sequences,
// and random traffic against a frame-level reference model.
module tb_row_frame_buffer;

    localparam int N = 4;
    localparam int P = 2;
    localparam int C = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic [P-1:0] row_ptr;
    logic         wr_valid;
    logic         wr_ready;
    logic [P-1:0] wr_row;
    logic [C-1:0] wr_data;
    logic         commit_valid;
    logic         commit_ready;
    logic         swap_done;
    logic [N-1:0] row_sel;
    logic [C-1:0] col_data;
    logic         frame_start;

    int tests = 0;
    int fails = 0;

    row_frame_buffer #(.NUM_ROWS(N), .PTR_BITS(P), .NUM_COLS(C)) dut (
        .clk(clk),
        .reset(reset),
        .row_ptr(row_ptr),
        .wr_valid(wr_valid),
        .wr_ready(wr_ready),
        .wr_row(wr_row),
        .wr_data(wr_data),
        .commit_valid(commit_valid),
        .commit_ready(commit_ready),
        .swap_done(swap_done),
        .row_sel(row_sel),
        .col_data(col_data),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Reference: the shown frame, the frame being built, and a pending flag
    logic [C-1:0] m_front [N];
    logic [C-1:0] m_back  [N];
    logic         m_pend;
    logic [N-1:0] e_rs;
    logic [C-1:0] e_col;
    logic         e_fs;
    logic         e_sd;

    typedef struct {
        logic [P-1:0] ptr;
        logic         wv;
        logic [P-1:0] wrow;
        logic [C-1:0] wd;
        logic         cv;
        logic [N-1:0] rs;
        logic [C-1:0] col;
        logic         fs;
        logic         sd;
        logic         rdy;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_front[i] = '0;
            m_back[i]  = '0;
        end
        m_pend = 1'b0;
    endtask

    task automatic model_edge(input logic [P-1:0] p, input logic wv,
                              input logic [P-1:0] wr, input logic [C-1:0] wd,
                              input logic cv);
        logic [C-1:0] t;
        e_rs  = '0;
        e_rs[p] = 1'b1;
        e_col = m_front[p];
        e_fs  = (p == 0);
        e_sd  = 1'b0;
        if (!m_pend) begin
            if (wv) m_back[wr] = wd;
            if (cv) m_pend = 1'b1;
        end else if (int'(p) == N - 1) begin
            for (int i = 0; i < N; i++) begin
                t          = m_front[i];
                m_front[i] = m_back[i];
                m_back[i]  = t;
            end
            m_pend = 1'b0;
            e_sd   = 1'b1;
        end
    endtask

    task automatic cyc(input logic [P-1:0] p, input logic wv,
                       input logic [P-1:0] wr, input logic [C-1:0] wd,
                       input logic cv);
        row_ptr      = p;
        wr_valid     = wv;
        wr_row       = wr;
        wr_data      = wd;
        commit_valid = cv;
        @(posedge clk);
        #1;
        model_edge(p, wv, wr, wd, cv);
        chk("m_row_sel", 32'(row_sel), 32'(e_rs));
        chk("m_col_data", 32'(col_data), 32'(e_col));
        chk("m_frame_start", 32'(frame_start), 32'(e_fs));
        chk("m_swap_done", 32'(swap_done), 32'(e_sd));
        chk("m_wr_ready", 32'(wr_ready), 32'(!m_pend));
        chk("m_commit_ready", 32'(commit_ready), 32'(!m_pend));
    endtask

    task automatic idle(input int r);
        cyc(P'(r), 1'b0, '0, '0, 1'b0);
    endtask

    initial begin
        tbl[0]  = '{2'd0, 1'b1, 2'd0, 8'h11, 1'b0, 4'b0001, 8'h00, 1'b1, 1'b0, 1'b1};
        tbl[1]  = '{2'd1, 1'b1, 2'd1, 8'h22, 1'b0, 4'b0010, 8'h00, 1'b0, 1'b0, 1'b1};
        tbl[2]  = '{2'd2, 1'b1, 2'd2, 8'h33, 1'b0, 4'b0100, 8'h00, 1'b0, 1'b0, 1'b1};
        tbl[3]  = '{2'd3, 1'b1, 2'd3, 8'h44, 1'b0, 4'b1000, 8'h00, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{2'd0, 1'b0, 2'd0, 8'h00, 1'b1, 4'b0001, 8'h00, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{2'd1, 1'b1, 2'd1, 8'hEE, 1'b0, 4'b0010, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{2'd2, 1'b0, 2'd0, 8'h00, 1'b0, 4'b0100, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{2'd3, 1'b0, 2'd0, 8'h00, 1'b0, 4'b1000, 8'h00, 1'b0, 1'b1, 1'b1};
        tbl[8]  = '{2'd0, 1'b0, 2'd0, 8'h00, 1'b0, 4'b0001, 8'h11, 1'b1, 1'b0, 1'b1};
        tbl[9]  = '{2'd1, 1'b0, 2'd0, 8'h00, 1'b0, 4'b0010, 8'h22, 1'b0, 1'b0, 1'b1};
        tbl[10] = '{2'd2, 1'b0, 2'd0, 8'h00, 1'b0, 4'b0100, 8'h33, 1'b0, 1'b0, 1'b1};
        tbl[11] = '{2'd3, 1'b0, 2'd0, 8'h00, 1'b0, 4'b1000, 8'h44, 1'b0, 1'b0, 1'b1};

        reset        = 1'b1;
        row_ptr      = '0;
        wr_valid     = 1'b0;
        wr_row       = '0;
        wr_data      = '0;
        commit_valid = 1'b0;
        model_reset();

        // Reset defaults with row_ptr free-running
        for (int i = 0; i < 3; i++) begin
            row_ptr = P'(i);
            @(posedge clk);
            #1;
        end
        chk("rst_row_sel", 32'(row_sel), 32'(0));
        chk("rst_col_data", 32'(col_data), 32'(0));
        chk("rst_frame_start", 32'(frame_start), 32'(0));
        chk("rst_swap_done", 32'(swap_done), 32'(0));
        chk("rst_wr_ready", 32'(wr_ready), 32'(1));
        chk("rst_commit_ready", 32'(commit_ready), 32'(1));
        reset = 1'b0;

        // Fill and swap
        for (int i = 0; i < 12; i++) begin
            cyc(tbl[i].ptr, tbl[i].wv, tbl[i].wrow, tbl[i].wd, tbl[i].cv);
            chk("tbl_row_sel", 32'(row_sel), 32'(tbl[i].rs));
            chk("tbl_col_data", 32'(col_data), 32'(tbl[i].col));
            chk("tbl_frame_start", 32'(frame_start), 32'(tbl[i].fs));
            chk("tbl_swap_done", 32'(swap_done), 32'(tbl[i].sd));
            chk("tbl_wr_ready", 32'(wr_ready), 32'(tbl[i].rdy));
        end

        // Commit on the wrap edge (with the last AA write) waits a full frame
        for (int r = 0; r < N; r++) cyc(P'(r), 1'b1, P'(r), 8'hAA, r == 3);
        chk("wrap_no_swap", 32'(swap_done), 32'(0));
        chk("wrap_commit_ready", 32'(commit_ready), 32'(0));
        for (int r = 0; r < N; r++) begin
            idle(r);
            chk("wrap_swap_timing", 32'(swap_done), 32'(r == 3));
        end

        // Tear-free: 0x55 frame committed while row 1 is sampled
        for (int r = 0; r < N; r++) begin
            cyc(P'(r), 1'b1, P'(r), 8'h55, 1'b0);
            chk("tear_pre_aa", 32'(col_data), 32'(8'hAA));
        end
        idle(0);
        cyc(2'd1, 1'b0, '0, '0, 1'b1);
        chk("tear_row1_aa", 32'(col_data), 32'(8'hAA));
        chk("tear_wr_refused", 32'(wr_ready), 32'(0));
        cyc(2'd2, 1'b1, 2'd2, 8'h99, 1'b0);
        chk("tear_row2_aa", 32'(col_data), 32'(8'hAA));
        chk("tear_wr_refused2", 32'(wr_ready), 32'(0));
        idle(3);
        chk("tear_row3_aa", 32'(col_data), 32'(8'hAA));
        chk("tear_swap_done", 32'(swap_done), 32'(1));
        idle(0);
        chk("tear_row0_55", 32'(col_data), 32'(8'h55));
        chk("tear_frame_start", 32'(frame_start), 32'(1));

        // Simultaneous write of row 2 and commit
        cyc(2'd1, 1'b1, 2'd2, 8'hF0, 1'b1);
        idle(2);
        idle(3);
        chk("simul_swap", 32'(swap_done), 32'(1));
        for (int r = 0; r < N; r++) begin
            idle(r);
            chk("simul_rows", 32'(col_data), 32'(r == 2 ? 8'hF0 : 8'hAA));
        end

        // Reset while a swap is pending
        cyc(2'd0, 1'b0, '0, '0, 1'b1);
        idle(1);
        idle(2);
        #3;
        reset = 1'b1;
        #1;
        chk("async_row_sel", 32'(row_sel), 32'(0));
        chk("async_col_data", 32'(col_data), 32'(0));
        chk("async_wr_ready", 32'(wr_ready), 32'(1));
        chk("async_commit_ready", 32'(commit_ready), 32'(1));
        model_reset();
        for (int r = 3; r < 5; r++) begin
            row_ptr = P'(r % N);
            @(posedge clk);
            #1;
            chk("rstp_swap_done", 32'(swap_done), 32'(0));
            chk("rstp_row_sel", 32'(row_sel), 32'(0));
        end
        reset = 1'b0;
        for (int r = 0; r < N; r++) begin
            idle(r);
            chk("rstp_rows_zero", 32'(col_data), 32'(0));
            chk("rstp_no_swap", 32'(swap_done), 32'(0));
        end

        // Random traffic: free-running pointer, then arbitrary pointer
        for (int i = 0; i < 800; i++) begin
            cyc(i < 400 ? P'(i % N) : P'($urandom_range(0, N - 1)),
                1'($urandom_range(0, 1)),
                P'($urandom_range(0, N - 1)),
                C'($urandom_range(0, 255)),
                $urandom_range(0, 5) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/row_frame_buffer.md
# row_frame_buffer

Double-buffered row store that sits directly downstream of `row_ptr_counter`. Each cycle it looks up the row addressed by the incoming `row_ptr` and presents a one-hot row select plus that row's column data. A host side loads a back buffer through a valid/ready write port and commits it. The commit becomes visible only at a frame boundary, so a displayed frame never tears.

## Interface
- `NUM_ROWS`, default 4: rows per frame; must be a power of two.
- `PTR_BITS`, default `$clog2(NUM_ROWS)`: width of the row pointer.
- `NUM_COLS`, default 8: bits per row.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  input  1  system clock, rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `row_ptr`  input  PTR_BITS  current row index from `row_ptr_counter`.
- `wr_valid`  input  1  host write request.
- `wr_ready`  output  1  back buffer accepts writes.
- `wr_row`  input  PTR_BITS  row to write.
- `wr_data`  input  NUM_COLS  row contents.
- `commit_valid`  input  1  request to swap the back buffer to the front.
- `commit_ready`  output  1  commit can be accepted.
- `swap_done`  output  1  one-cycle pulse when a swap takes effect.
- `row_sel`  output  NUM_ROWS  one-hot select of the displayed row.
- `col_data`  output  NUM_COLS  data of the displayed row.
- `frame_start`  output  1  high while the displayed row is row 0.

## Operation
- Storage: two banks, `bank[0]` and `bank[1]`, each NUM_ROWS × NUM_COLS registers. `front_sel` selects the displayed bank; the other bank is the back bank.
- Control FSM has two states.
  - **OPEN** (reset state):
    - `wr_ready` = 1 and `commit_ready` = 1.
    - A write handshake (`wr_valid` & `wr_ready`) stores `wr_data` into back bank row `wr_row`.
    - A commit handshake (`commit_valid` & `commit_ready`) moves the FSM to PENDING.
  - **PENDING**:
    - `wr_ready` = 0 and `commit_ready` = 0.
    - On the edge where the sampled `row_ptr` == NUM_ROWS-1: toggle `front_sel`, pulse `swap_done` for one cycle, return to OPEN.
- `wr_ready` and `commit_ready` are decoded combinationally from the state only; they do not depend on `wr_valid` or `commit_valid`.
- A write and a commit accepted in the same cycle: the write lands in the back bank and is included in the swap.
- After a swap the new back bank holds the old front frame. No copy or clear is performed; the host rewrites whatever rows it needs.
- Display path, one register stage:
  - `row_sel` = one-hot(`row_ptr`).
  - `col_data` = front bank[`row_ptr`].
  - `frame_start` = (`row_ptr` == 0).

## Timing
- Reset values:
  - State OPEN, `front_sel` = 0, both banks all-zero.
  - `row_sel` = 0, `col_data` = 0, `frame_start` = 0, `swap_done` = 0.
  - `wr_ready` = 1, `commit_ready` = 1.
- Display latency is 1 cycle: `row_ptr` = r sampled at edge t appears on `row_sel`/`col_data` after edge t.
- The read at edge t uses the `front_sel` value held before edge t.
  - Row NUM_ROWS-1 of a swapping frame therefore still shows the old bank.
  - The following row 0 shows the new bank.
  - `swap_done` is high in the same cycle that row NUM_ROWS-1 (old bank) is displayed.
- Commit to swap takes at least 1 cycle and at most NUM_ROWS cycles after the commit handshake, assuming `row_ptr` free-runs.
  - A commit accepted on the edge where `row_ptr` == NUM_ROWS-1 does not swap on that edge; it waits for the next wrap.
- A write accepted at edge t is visible on the display no earlier than the first row-0 read after the swap.
- Reset asserted mid-PENDING:
  - The pending swap is discarded and `front_sel` returns to 0.
  - All outputs go to their reset values immediately, without waiting for a clock edge.
- Deassertion of `reset` is synchronous to `clk` at the system level; the first display output is valid 1 edge after release.

## Test plan
- **Reset defaults.** Assert reset with `row_ptr` free-running -> `row_sel` = 0, `col_data` = 0, `wr_ready` = 1, `commit_ready` = 1, and all outputs clear asynchronously mid-cycle.
- **Fill and swap.** Write rows 0..3 = 0x11, 0x22, 0x33, 0x44, then commit.
  - `swap_done` pulses when `row_ptr` = 3 is sampled.
  - The next four cycles show `row_sel` = 0001/0010/0100/1000 with `col_data` = 0x11/0x22/0x33/0x44, and `frame_start` = 1 on the first of them.
- **Tear-free display.** With 0xAA showing on all rows, commit a 0x55 frame while `row_ptr` = 1.
  - Rows 1..3 still show 0xAA; row 0 of the next frame shows 0x55.
  - Writes are refused (`wr_ready` = 0) until `swap_done`.
- **Commit at the wrap edge.** Commit accepted on the edge sampling `row_ptr` = 3 -> no swap on that edge; swap occurs 4 cycles later.
- **Simultaneous write and commit.** Write row 2 = 0xF0 in the same cycle as commit -> row 2 shows 0xF0 after the swap.
- **Reset during PENDING.** Assert reset between commit and wrap -> `swap_done` never pulses, `front_sel` = 0, and after release all rows show 0x00.
